// File: rtl/crc_pkg.sv
// Shared types and well-known CRC constants for the CRC frame engine family.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } crc_state_t;

    localparam logic [7:0]  CRC8_POLY_AB = 8'hAB;
    localparam logic [7:0]  CRC8_POLY_07 = 8'h07;
    localparam logic [15:0] CRC16_CCITT  = 16'h1021;
    localparam logic [31:0] CRC32_IEEE   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

endpackage

// File: rtl/crc_frame_engine_if.sv
// Beat/result bundle between the data source (master) and the CRC frame engine (slave).
interface crc_frame_engine_if #(
    parameter int unsigned CRC_W  = 8,
    parameter int unsigned DATA_W = 1,
    parameter int unsigned CNT_W  = 16
);
    logic              ENABLE;
    logic              START;
    logic [DATA_W-1:0] DIN;
    logic              DVALID;
    logic              DLAST;
    logic [CRC_W-1:0]  CRC;
    logic [CRC_W-1:0]  CRC_OUT;
    logic              CRC_DONE;
    logic              RESIDUE_OK;
    logic              BUSY;
    logic [CNT_W-1:0]  BEAT_CNT;

    modport master (
        output ENABLE, START, DIN, DVALID, DLAST,
        input  CRC, CRC_OUT, CRC_DONE, RESIDUE_OK, BUSY, BEAT_CNT
    );

    modport slave (
        input  ENABLE, START, DIN, DVALID, DLAST,
        output CRC, CRC_OUT, CRC_DONE, RESIDUE_OK, BUSY, BEAT_CNT
    );

endinterface

// File: rtl/crc_step_comb.sv
// Combinational DATA_W-bit CRC advance: applies one serial LFSR step per data bit.
module crc_step_comb #(
    parameter int unsigned      CRC_W  = 8,
    parameter int unsigned      DATA_W = 1,
    parameter logic [CRC_W-1:0] POLY   = 8'hAB
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    input  logic              reflect,
    output logic [CRC_W-1:0]  crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            // reflect selects LSB-first consumption of the beat
            if ((reflect ? data[i] : data[DATA_W-1-i]) ^ crc_out[CRC_W-1])
                crc_out = (crc_out << 1) ^ POLY;
            else
                crc_out = crc_out << 1;
        end
    end

endmodule

// File: rtl/crc_frame_engine.sv
// Frame-aware CRC generator/checker with IDLE/RUN/DONE framing FSM.
// Define CRC_REFLECT_EN for LSB-first input and bit-reversed CRC_OUT.
module crc_frame_engine
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W   = 8,
    parameter int unsigned      DATA_W  = 1,
    parameter logic [CRC_W-1:0] POLY    = 8'hAB,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOROUT  = '0,
    parameter logic [CRC_W-1:0] RESIDUE = '0,
    parameter int unsigned      CNT_W   = 16
) (
    input  logic                BITSTRB,
    input  logic                CLEAR,
    crc_frame_engine_if.slave   bus
);

`ifdef CRC_REFLECT_EN
    localparam logic REFLECT = 1'b1;
`else
    localparam logic REFLECT = 1'b0;
`endif

    crc_state_t       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] out_q, out_d;
    logic             rok_q, rok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             last_beat;
    logic [CRC_W-1:0] base;
    logic [CRC_W-1:0] step_out;
    logic [CRC_W-1:0] final_out;
    logic [CNT_W-1:0] cnt_base;

    // START re-seeds the register in the same cycle its beat is folded in
    assign accept    = bus.ENABLE & bus.DVALID & ((state_q == RUN) | bus.START);
    assign last_beat = accept & bus.DLAST;
    assign base      = bus.START ? INIT : crc_q;
    assign cnt_base  = bus.START ? '0 : cnt_q;

    crc_step_comb #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_step (
        .crc_in  (base),
        .data    (bus.DIN),
        .reflect (REFLECT),
        .crc_out (step_out)
    );

`ifdef CRC_REFLECT_EN
    always_comb begin
        final_out = '0;
        for (int unsigned i = 0; i < CRC_W; i++)
            final_out[i] = step_out[CRC_W-1-i];
        final_out = final_out ^ XOROUT;
    end
`else
    assign final_out = step_out ^ XOROUT;
`endif

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rok_d   = rok_q;
        if (bus.ENABLE) begin
            if (bus.START) begin
                crc_d = INIT;
                cnt_d = '0;
            end
            if (accept) begin
                crc_d = step_out;
                cnt_d = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
            end
            if (last_beat) begin
                out_d = final_out;
                rok_d = (step_out == RESIDUE);
            end
            if (bus.START) begin
                state_d = last_beat ? DONE : RUN;
            end else begin
                unique case (state_q)
                    RUN:     if (last_beat) state_d = DONE;
                    DONE:    state_d = IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge BITSTRB) begin
        if (CLEAR) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            out_q   <= '0;
            rok_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            out_q   <= out_d;
            rok_q   <= rok_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.CRC        = crc_q;
    assign bus.CRC_OUT    = out_q;
    assign bus.CRC_DONE   = (state_q == DONE);
    assign bus.RESIDUE_OK = rok_q;
    assign bus.BUSY       = (state_q == RUN);
    assign bus.BEAT_CNT   = cnt_q;

endmodule

// File: tb/tb_crc_frame_engine.sv
// Bench for crc_frame_engine: directed literal checks on three configurations plus a
// randomized run of the CRC-8/0x07 byte engine against a frame-level queue model.
module tb_crc_frame_engine;
    import crc_pkg::*;

    logic clk   = 1'b0;
    logic clear = 1'b1;
    bit   cmp_on = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    crc_frame_engine_if #(.CRC_W(8),  .DATA_W(1), .CNT_W(16)) ifa ();
    crc_frame_engine_if #(.CRC_W(8),  .DATA_W(8), .CNT_W(4))  ifb ();
    crc_frame_engine_if #(.CRC_W(32), .DATA_W(8), .CNT_W(16)) ifc ();

    crc_frame_engine u_a (.BITSTRB(clk), .CLEAR(clear), .bus(ifa));

    crc_frame_engine #(
        .CRC_W(8), .DATA_W(8), .POLY(CRC8_POLY_07), .INIT(8'h00),
        .XOROUT(8'h00), .RESIDUE(8'h00), .CNT_W(4)
    ) u_b (.BITSTRB(clk), .CLEAR(clear), .bus(ifb));

    crc_frame_engine #(
        .CRC_W(32), .DATA_W(8), .POLY(CRC32_IEEE), .INIT(CRC32_INIT),
        .XOROUT(CRC32_XOROUT), .CNT_W(16)
    ) u_c (.BITSTRB(clk), .CLEAR(clear), .bus(ifc));

    // ---------------- reference model for u_b ----------------
    logic [7:0] q[$];          // beats accepted in the current/last frame
    bit         m_in;          // a frame is open
    bit         m_done;        // the frame just completed
    logic [7:0] m_out;
    bit         m_rok;

    function automatic logic [31:0] mstep(input logic [31:0] crc, input logic [31:0] data,
                                          input int w, input int dw, input logic [31:0] poly);
        logic [31:0] mask;
        bit b;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        for (int k = 0; k < dw; k++) begin
`ifdef CRC_REFLECT_EN
            b = data[k];
`else
            b = data[dw-1-k];
`endif
            if (b ^ crc[w-1]) crc = ((crc << 1) ^ poly) & mask;
            else              crc = (crc << 1) & mask;
        end
        return crc;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[7-k];
        return r;
    endfunction

    function automatic logic [7:0] crc_b_now();
        logic [31:0] c;
        c = 32'h0;
        foreach (q[k]) c = mstep(c, {24'h0, q[k]}, 8, 8, 32'h07);
        return c[7:0];
    endfunction

    function automatic logic [7:0] outx_b(input logic [7:0] f);
`ifdef CRC_REFLECT_EN
        return rev8(f);
`else
        return f;
`endif
    endfunction

    always @(posedge clk) begin : model_b
        bit acc, fin;
        logic [7:0] f;
        if (clear) begin
            q.delete();
            m_in   <= 1'b0;
            m_done <= 1'b0;
            m_out  <= 8'h00;
            m_rok  <= 1'b0;
        end else if (ifb.ENABLE) begin
            acc = ifb.DVALID && (m_in || ifb.START);
            fin = acc && ifb.DLAST;
            if (ifb.START) q.delete();
            if (acc) q.push_back(ifb.DIN);
            if (fin) begin
                f = crc_b_now();
                m_out <= outx_b(f);
                m_rok <= (f == 8'h00);
            end
            if (ifb.START || m_in) begin
                m_in   <= !fin;
                m_done <= fin;
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare_b
        int exp_cnt;
        if (cmp_on) begin
            exp_cnt = (q.size() > 15) ? 15 : q.size();
            check("b_crc",  {24'h0, ifb.CRC},        {24'h0, crc_b_now()});
            check("b_out",  {24'h0, ifb.CRC_OUT},    {24'h0, m_out});
            check("b_done", {31'h0, ifb.CRC_DONE},   {31'h0, m_done});
            check("b_busy", {31'h0, ifb.BUSY},       {31'h0, m_in});
            check("b_rok",  {31'h0, ifb.RESIDUE_OK}, {31'h0, m_rok});
            check("b_cnt",  {28'h0, ifb.BEAT_CNT},   exp_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv_a(input bit st, input bit dv, input bit dl, input bit d);
        ifa.ENABLE = 1'b1; ifa.START = st; ifa.DVALID = dv; ifa.DLAST = dl; ifa.DIN = d;
        tick();
    endtask

    task automatic drv_b(input bit clr, input bit en, input bit st, input bit dv,
                         input bit dl, input logic [7:0] d);
        clear = clr;
        ifb.ENABLE = en; ifb.START = st; ifb.DVALID = dv; ifb.DLAST = dl; ifb.DIN = d;
        tick();
        clear = 1'b0;
    endtask

    task automatic drv_c(input bit st, input bit dv, input bit dl, input logic [7:0] d);
        ifc.ENABLE = 1'b1; ifc.START = st; ifc.DVALID = dv; ifc.DLAST = dl; ifc.DIN = d;
        tick();
    endtask

    // "123456789" with START on the first byte; optional appended tail byte carries DLAST
    task automatic send_msg(input bit use_tail, input logic [7:0] tail);
        for (int i = 0; i < 9; i++)
            drv_b(1'b0, 1'b1, i == 0, 1'b1, (i == 8) && !use_tail, 8'h31 + 8'(i));
        if (use_tail) drv_b(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, tail);
    endtask

    initial begin
        ifa.ENABLE = 1'b0; ifa.START = 1'b0; ifa.DVALID = 1'b0; ifa.DLAST = 1'b0; ifa.DIN = '0;
        ifb.ENABLE = 1'b0; ifb.START = 1'b0; ifb.DVALID = 1'b0; ifb.DLAST = 1'b0; ifb.DIN = '0;
        ifc.ENABLE = 1'b0; ifc.START = 1'b0; ifc.DVALID = 1'b0; ifc.DLAST = 1'b0; ifc.DIN = '0;
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        cmp_on = 1'b1;

        // reset values
        check("rst_a_crc",  ifa.CRC, 32'h00);
        check("rst_a_out",  ifa.CRC_OUT, 32'h00);
        check("rst_a_done", ifa.CRC_DONE, 0);
        check("rst_a_busy", ifa.BUSY, 0);
        check("rst_a_cnt",  ifa.BEAT_CNT, 0);
        check("rst_c_crc",  ifc.CRC, 32'hFFFF_FFFF);

        // 1-bit engine, poly 0xAB: bits 1,0
        drv_a(1'b1, 1'b1, 1'b0, 1'b1);
        check("a_crc_beat1", ifa.CRC, 32'hAB);
        check("a_busy",      ifa.BUSY, 1);
        drv_a(1'b0, 1'b1, 1'b1, 1'b0);
        check("a_crc_beat2", ifa.CRC, 32'hFD);
`ifdef CRC_REFLECT_EN
        check("a_out",       ifa.CRC_OUT, 32'hBF);
`else
        check("a_out",       ifa.CRC_OUT, 32'hFD);
`endif
        check("a_done",      ifa.CRC_DONE, 1);
        check("a_cnt",       ifa.BEAT_CNT, 2);
        drv_a(1'b0, 1'b0, 1'b0, 1'b0);
        check("a_done_drop", ifa.CRC_DONE, 0);
        ifa.ENABLE = 1'b0;

        // CRC-32 "123456789"
        for (int i = 0; i < 9; i++)
            drv_c(i == 0, 1'b1, i == 8, 8'h31 + 8'(i));
`ifdef CRC_REFLECT_EN
        check("c_out", ifc.CRC_OUT, 32'hCBF4_3926);
`else
        check("c_out", ifc.CRC_OUT, 32'hFC89_1918);
`endif
        check("c_done", ifc.CRC_DONE, 1);
        check("c_cnt",  ifc.BEAT_CNT, 9);
        ifc.ENABLE = 1'b0;

        // CRC-8/0x07 check value and residue
        send_msg(1'b0, 8'h00);
`ifndef CRC_REFLECT_EN
        check("b_check_f4", ifb.CRC_OUT, 32'hF4);
`endif
        check("b_msg_done", ifb.CRC_DONE, 1);
        drv_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_msg(1'b1, 8'hF4);
`ifndef CRC_REFLECT_EN
        check("b_residue_ok", ifb.RESIDUE_OK, 1);
`endif
        send_msg(1'b1, 8'hF5);
        check("b_residue_bad", ifb.RESIDUE_OK, 0);

        // ENABLE low mid-frame with DVALID toggling
        for (int i = 0; i < 4; i++)
            drv_b(1'b0, 1'b1, i == 0, 1'b1, 1'b0, 8'h31 + 8'(i));
        for (int i = 0; i < 3; i++)
            drv_b(1'b0, 1'b0, 1'b0, i[0], i == 1, 8'($urandom));
        check("b_freeze_cnt",  ifb.BEAT_CNT, 4);
        check("b_freeze_busy", ifb.BUSY, 1);
        for (int i = 4; i < 9; i++)
            drv_b(1'b0, 1'b1, 1'b0, 1'b1, i == 8, 8'h31 + 8'(i));
`ifndef CRC_REFLECT_EN
        check("b_freeze_out", ifb.CRC_OUT, 32'hF4);
`endif

        // START re-asserted after 4 beats aborts the frame
        for (int i = 0; i < 4; i++)
            drv_b(1'b0, 1'b1, i == 0, 1'b1, 1'b0, 8'hA0 + 8'(i));
        drv_b(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h31);
        check("b_abort_done", ifb.CRC_DONE, 0);
        check("b_abort_cnt",  ifb.BEAT_CNT, 1);
        for (int i = 1; i < 9; i++)
            drv_b(1'b0, 1'b1, 1'b0, 1'b1, i == 8, 8'h31 + 8'(i));
`ifndef CRC_REFLECT_EN
        check("b_abort_out", ifb.CRC_OUT, 32'hF4);
`endif
        check("b_abort_cnt9", ifb.BEAT_CNT, 9);

        // beat counter saturates at all-ones (4-bit)
        for (int i = 0; i < 20; i++)
            drv_b(1'b0, 1'b1, i == 0, 1'b1, 1'b0, 8'($urandom));
        check("b_cnt_sat", ifb.BEAT_CNT, 15);

        // CLEAR mid-frame coincident with DVALID, then DVALID without START
        drv_b(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
        check("b_clr_crc",  ifb.CRC, 32'h00);
        check("b_clr_out",  ifb.CRC_OUT, 32'h00);
        check("b_clr_busy", ifb.BUSY, 0);
        check("b_clr_cnt",  ifb.BEAT_CNT, 0);
        drv_b(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
        check("b_ign_crc",  ifb.CRC, 32'h00);
        check("b_ign_done", ifb.CRC_DONE, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drv_b($urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 14) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0,
                  8'($urandom));
        end

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/crc_frame_engine.md
Name: crc_frame_engine

Overview:
Parametrised, frame-aware CRC generator/checker and the successor to the 1-bit serial CRC8.
- Processes DATA_W bits per accepted beat with a configurable polynomial, init value and output XOR.
- Small FSM tracks frame start and end, emits the final CRC with a done pulse, and flags a residue match for receive-side checking.
- Sits between the serial/byte datapath and the packet framer, in both TX (generate) and RX (check) roles.

Parameters:
CRC_W, 8, CRC register width (1..32)
DATA_W, 1, bits consumed per accepted beat (1..32)
POLY, 8'hAB, generator polynomial without the implicit top bit
INIT, 0, CRC register value loaded on START
XOROUT, 0, XOR applied to CRC_OUT
RESIDUE, 0, expected register value after data plus appended CRC
CNT_W, 16, width of the beat counter

Ports:
BITSTRB  in  1  clock; all state changes on its rising edge
CLEAR  in  1  synchronous active-high reset
ENABLE  in  1  global advance enable; low freezes all state
START  in  1  load INIT and open a frame
DIN  in  DATA_W  data beat
DVALID  in  1  DIN valid
DLAST  in  1  qualifies the final beat of a frame
CRC  out  CRC_W  running CRC register
CRC_OUT  out  CRC_W  latched final CRC ^ XOROUT
CRC_DONE  out  1  high while FSM is in DONE
RESIDUE_OK  out  1  latched (final register == RESIDUE)
BUSY  out  1  high in RUN
BEAT_CNT  out  CNT_W  beats accepted in the current/last frame, saturating

Behaviour:
- Reset (CLEAR=1 at an edge, overrides everything including ENABLE=0):
  - CRC=INIT, CRC_OUT=0, CRC_DONE=0, RESIDUE_OK=0, BUSY=0, BEAT_CNT=0, state=IDLE.
- Step per bit b: inv = b ^ crc[CRC_W-1]; crc = (crc<<1) ^ (inv ? POLY : 0), truncated to CRC_W.
- Bit order: DIN[DATA_W-1] first.
- A beat is DATA_W successive steps applied in one cycle.
- Accept condition: ENABLE & DVALID & (state==RUN | START).
- Latency: CRC reflects an accepted beat at the next edge.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN on START.
  - RUN -> DONE on an accepted beat with DLAST.
  - DONE -> IDLE after one enabled cycle; DONE -> RUN if START is asserted in that cycle.
- START handling:
  - Loads INIT and clears BEAT_CNT.
  - If DVALID is high in the same cycle, that beat is processed from INIT and counts as beat 1.
  - START & DVALID & DLAST together gives a one-beat frame and goes straight to DONE.
- START in RUN: aborts the frame and re-initialises; no CRC_DONE and no CRC_OUT update.
- DVALID in IDLE or DONE without START: ignored; CRC unchanged.
- DLAST without DVALID: ignored.
- On the edge accepting the DLAST beat:
  - CRC_OUT <= next ^ XOROUT.
  - RESIDUE_OK <= (next == RESIDUE).
  - Both hold until the next DLAST or CLEAR.
- CRC_DONE is high exactly while in DONE (one cycle when ENABLE is high).
- ENABLE=0: no state, CRC or counter change; all outputs hold.
- BEAT_CNT increments per accepted beat and saturates at all-ones.
- CLEAR mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
CRC_REFLECT_EN
- Defined:
  - Input bits are consumed LSB first (DIN[0] first).
  - CRC_OUT is the bit-reversed final register ^ XOROUT.
  - RESIDUE compare is still on the unreflected register.
- Undefined: MSB-first input and unreflected CRC_OUT, as above.

Decomposition:
- Package crc_pkg:
  - FSM state enum (IDLE/RUN/DONE).
  - Polynomial constants: CRC8_POLY_AB=8'hAB, CRC8_POLY_07=8'h07, CRC16_CCITT=16'h1021, CRC32_IEEE=32'h04C11DB7.
  - CRC32_INIT/XOROUT=32'hFFFFFFFF.
- Sub-module crc_step_comb: purely combinational DATA_W-bit next-value function (crc_in, data, reflect) -> crc_out, unrolled loop. Reused by a future parallel scrambler.

Test Plan:
1. Defaults, CRC_W=8, DATA_W=1: START+DVALID+DIN=1, then DIN=0 with DLAST -> CRC after beat 1 = 0xAB; CRC_OUT=0xFD; CRC_DONE high 1 cycle; BEAT_CNT=2.
2. CRC_W=8, DATA_W=8, POLY=0x07: ASCII "123456789" (0x31..0x39), DLAST on 0x39 -> CRC_OUT=0xF4; then a new frame "123456789",0xF4 -> RESIDUE_OK=1, and with 0xF5 -> RESIDUE_OK=0.
3. CRC_REFLECT_EN, CRC_W=32, DATA_W=8, POLY=0x04C11DB7, INIT=XOROUT=0xFFFFFFFF: "123456789" -> CRC_OUT=0xCBF43926.
4. Test 2 setup, ENABLE low for 3 cycles mid-frame with DVALID toggling -> CRC and BEAT_CNT frozen; final CRC_OUT still 0xF4.
5. Test 2 setup, START reasserted after 4 beats, then a full "123456789" -> no CRC_DONE at abort; CRC_OUT=0xF4; BEAT_CNT=9.
6. CLEAR asserted mid-frame coincident with DVALID -> next cycle all outputs at reset values, state IDLE; following DVALID without START ignored (CRC=INIT).
